// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit for the in-order RV32 pipeline.
// A shadow pipeline of in-flight writers feeds NUM_SRC bypassed operands to ID.
module fwd_hazard_unit #(
  parameter int XLEN      = 32,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_fire,
  input  logic                    id_rd_we,
  input  logic                    id_is_load,
  input  logic [4:0]              id_rd_addr,
  input  logic [5*NUM_SRC-1:0]    id_rs_addr,
  input  logic [XLEN*NUM_SRC-1:0] id_rs_data,
  input  logic [XLEN-1:0]         ex_result,
  input  logic [XLEN-1:0]         mem_rdata,
  output logic [XLEN*NUM_SRC-1:0] id_rs_out,
  output logic                    stall,
  output logic [15:0]             stall_cnt
);

  logic [FWD_DEPTH-1:0] vld_q, vld_d;
  logic [FWD_DEPTH-1:0] we_q, we_d;
  logic [FWD_DEPTH-1:0] ld_q, ld_d;
  logic [FWD_DEPTH-1:0] rdy_q, rdy_d;
  logic [4:0]           rd_q   [FWD_DEPTH];
  logic [4:0]           rd_d   [FWD_DEPTH];
  logic [XLEN-1:0]      data_q [FWD_DEPTH];
  logic [XLEN-1:0]      data_d [FWD_DEPTH];
  logic [15:0]          cnt_q, cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A stage can supply data if captured already, or if its producer drives it this cycle.
  function automatic logic stage_avail(input int k, input logic ld, input logic rdy);
    return rdy | ((k == 0) & ~ld) | ((k == LOAD_LAT) & ld);
  endfunction

  // Stage 0 takes the issuing instruction; every older stage takes its younger neighbour.
  always_comb begin
    vld_d     = '0;
    we_d      = '0;
    ld_d      = '0;
    rdy_d     = '0;
    vld_d[0]  = id_fire;
    we_d[0]   = id_fire & id_rd_we;
    ld_d[0]   = id_fire & id_is_load;
    rd_d[0]   = id_fire ? id_rd_addr : 5'd0;
    data_d[0] = '0;
    for (int k = 1; k < FWD_DEPTH; k++) begin
      vld_d[k]  = vld_q[k-1];
      we_d[k]   = we_q[k-1];
      ld_d[k]   = ld_q[k-1];
      rd_d[k]   = rd_q[k-1];
      rdy_d[k]  = rdy_q[k-1];
      data_d[k] = data_q[k-1];
      if (vld_q[k-1] && !rdy_q[k-1]) begin
        if ((k - 1) == 0 && !ld_q[k-1]) begin
          rdy_d[k]  = 1'b1;
          data_d[k] = ex_result;
        end else if ((k - 1) == LOAD_LAT && ld_q[k-1]) begin
          rdy_d[k]  = 1'b1;
          data_d[k] = mem_rdata;
        end
      end
    end
  end

  // Oldest-to-youngest scan so the youngest matching writer is the last to override.
  always_comb begin : fwd_sel
    logic [4:0]      rs;
    logic            avail;
    logic [XLEN-1:0] val;
    id_rs_out = id_rs_data;
    stall     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs    = id_rs_addr[5*i +: 5];
      avail = 1'b1;
      val   = id_rs_data[XLEN*i +: XLEN];
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (vld_q[k] && we_q[k] && (rd_q[k] != 5'd0) && (rd_q[k] == rs)) begin
          avail = stage_avail(k, ld_q[k], rdy_q[k]);
          if (rdy_q[k])
            val = data_q[k];
          else if (k == 0)
            val = ex_result;
          else
            val = mem_rdata;
        end
      end
      if (avail)
        id_rs_out[XLEN*i +: XLEN] = val;
      stall = stall | ~avail;
    end
  end

  always_comb begin
    cnt_d = stall ? sat_inc16(cnt_q) : cnt_q;
  end

  // Shadow pipeline stage boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      we_q  <= '0;
      ld_q  <= '0;
      rdy_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        rd_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      we_q  <= we_d;
      ld_q  <= ld_d;
      rdy_q <= rdy_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        rd_q[k]   <= rd_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios plus randomized traffic against an age-based model.
module tb_fwd_hazard_unit;
  localparam int XLEN = 32;
  localparam int NSRC = 2;
  localparam int DEPTH = 3;
  localparam int LL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_fire, id_rd_we, id_is_load;
  logic [4:0] id_rd_addr;
  logic [5*NSRC-1:0] id_rs_addr;
  logic [XLEN*NSRC-1:0] id_rs_data;
  logic [XLEN-1:0] ex_result, mem_rdata;
  logic [XLEN*NSRC-1:0] id_rs_out;
  logic stall;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.XLEN(XLEN), .NUM_SRC(NSRC), .FWD_DEPTH(DEPTH), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst_n(rst_n), .id_fire(id_fire), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_rd_addr(id_rd_addr), .id_rs_addr(id_rs_addr),
    .id_rs_data(id_rs_data), .ex_result(ex_result), .mem_rdata(mem_rdata),
    .id_rs_out(id_rs_out), .stall(stall), .stall_cnt(stall_cnt)
  );

  // One record per in-flight instruction, indexed by cycles since issue.
  typedef struct {
    bit v; bit we; bit ld; bit [4:0] rd; logic [XLEN-1:0] val;
  } ent_t;
  ent_t pipe[$];
  int unsigned m_cnt;
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    ent_t e;
    e.v = 0; e.we = 0; e.ld = 0; e.rd = 0; e.val = '0;
    pipe.delete();
    for (int a = 0; a < DEPTH; a++) pipe.push_back(e);
    m_cnt = 0;
  endfunction

  // Youngest matching writer decides; a load's value exists only from age LL on.
  function automatic void model_eval(output bit st, output logic [XLEN*NSRC-1:0] ov);
    ent_t e;
    bit found;
    logic [4:0] rs;
    st = 0;
    ov = id_rs_data;
    for (int i = 0; i < NSRC; i++) begin
      rs = id_rs_addr[5*i +: 5];
      found = 0;
      for (int a = 0; a < DEPTH; a++) begin
        e = pipe[a];
        if (!found && e.v && e.we && e.rd != 0 && e.rd == rs) begin
          found = 1;
          if (!e.ld) ov[XLEN*i +: XLEN] = (a == 0) ? ex_result : e.val;
          else if (a < LL) st = 1;
          else if (a == LL) ov[XLEN*i +: XLEN] = mem_rdata;
          else ov[XLEN*i +: XLEN] = e.val;
        end
      end
    end
  endfunction

  function automatic void model_edge(input bit st);
    ent_t e;
    e = pipe[0];
    if (e.v && !e.ld) begin e.val = ex_result; pipe[0] = e; end
    e = pipe[LL];
    if (e.v && e.ld) begin e.val = mem_rdata; pipe[LL] = e; end
    void'(pipe.pop_back());
    e.v = id_fire; e.we = id_fire & id_rd_we; e.ld = id_fire & id_is_load;
    e.rd = id_rd_addr; e.val = '0;
    pipe.push_front(e);
    if (st && m_cnt < 32'hFFFF) m_cnt++;
  endfunction

  task automatic drive(input bit fire, input bit we, input bit ld, input bit [4:0] rd,
                       input bit [4:0] rs0, input bit [4:0] rs1,
                       input logic [XLEN-1:0] rf0, input logic [XLEN-1:0] rf1,
                       input logic [XLEN-1:0] ex, input logic [XLEN-1:0] mem);
    id_fire = fire; id_rd_we = we; id_is_load = ld; id_rd_addr = rd;
    id_rs_addr = {rs1, rs0};
    id_rs_data = {rf1, rf0};
    ex_result = ex; mem_rdata = mem;
  endtask

  task automatic cmp_model();
    bit st;
    logic [XLEN*NSRC-1:0] ov;
    #1;
    model_eval(st, ov);
    chk_eq("stall", stall, st);
    if (!st) chk_eq("rs_out", id_rs_out, ov);
    chk_eq("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic tick();
    bit st;
    logic [XLEN*NSRC-1:0] ov;
    model_eval(st, ov);
    @(posedge clk);
    model_edge(st);
    @(negedge clk);
  endtask

  task automatic flush();
    for (int n = 0; n < DEPTH; n++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, $urandom, $urandom);
      cmp_model();
      tick();
    end
  endtask

  initial begin
    bit st;
    logic [XLEN*NSRC-1:0] ov;
    model_reset();
    drive(0, 0, 0, 0, 5, 7, 32'hAAAA, 32'hBBBB, 0, 0);
    #1;
    chk_eq("rst_stall", stall, 1'b0);
    chk_eq("rst_out", id_rs_out, {32'hBBBB, 32'hAAAA});
    chk_eq("rst_cnt", stall_cnt, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // add x5 issues, sits in EX with result 0x11, then is read from stage 1.
    drive(1, 1, 0, 5, 0, 0, 0, 0, 32'h0, 0);         cmp_model(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h11, 0);        cmp_model(); tick();
    drive(0, 0, 0, 0, 5, 0, 0, 0, 32'h999, 0);       cmp_model();
    chk_eq("plan_fwd_s1", id_rs_out[31:0], 32'h11);
    tick(); flush();

    drive(1, 1, 0, 7, 0, 0, 0, 0, 32'h0, 0);         cmp_model(); tick();
    drive(0, 0, 0, 0, 0, 7, 0, 0, 32'hDEAD, 0);      cmp_model();
    chk_eq("plan_b2b", id_rs_out[63:32], 32'hDEAD);
    tick(); flush();

    drive(1, 1, 1, 3, 0, 0, 0, 0, 32'h0, 0);         cmp_model(); tick();
    drive(0, 0, 0, 0, 3, 0, 0, 0, 32'h5, 32'h1);     cmp_model();
    chk_eq("plan_lu_stall", stall, 1'b1);
    tick();
    drive(0, 0, 0, 0, 3, 0, 0, 0, 32'h6, 32'hCAFE);  cmp_model();
    chk_eq("plan_lu_clear", stall, 1'b0);
    chk_eq("plan_lu_data", id_rs_out[31:0], 32'hCAFE);
    chk_eq("plan_lu_cnt", stall_cnt, 16'd1);
    tick(); flush();

    drive(1, 1, 0, 4, 0, 0, 0, 0, 32'h0, 0);         cmp_model(); tick();
    drive(1, 1, 0, 4, 0, 0, 0, 0, 32'h1, 0);         cmp_model(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 0);         cmp_model(); tick();
    drive(0, 0, 0, 0, 4, 0, 0, 0, 32'h3, 0);         cmp_model();
    chk_eq("plan_prio", id_rs_out[31:0], 32'h2);
    tick(); flush();

    drive(1, 1, 0, 4, 0, 0, 0, 0, 32'h0, 0);         cmp_model(); tick();
    drive(1, 1, 0, 4, 0, 0, 0, 0, 32'h1, 0);         cmp_model(); tick();
    drive(1, 1, 1, 4, 0, 0, 0, 0, 32'h2, 0);         cmp_model(); tick();
    drive(0, 0, 0, 0, 4, 0, 0, 0, 32'h3, 32'h4);     cmp_model();
    chk_eq("plan_prio_load", stall, 1'b1);
    tick(); flush();

    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);         cmp_model(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h77, 32'h55, 0);   cmp_model();
    chk_eq("plan_x0", id_rs_out, {32'h77, 32'h0});
    chk_eq("plan_x0_stall", stall, 1'b0);
    tick();

    // Random traffic on x0..x3 to provoke dense hazards; id_fire honours the stall.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, $urandom);
      model_eval(st, ov);
      if (st) id_fire = 1'b0;
      cmp_model();
      tick();
    end

    // Hold a load to x3 in EX every cycle so the stall never resolves.
    for (int n = 0; n < 70000; n++) begin
      drive(1, 1, 1, 3, 3, 0, 0, 0, $urandom, $urandom);
      tick();
    end
    cmp_model();
    chk_eq("sat_cnt", stall_cnt, 16'hFFFF);
    chk_eq("sat_stall", stall, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_eq("async_rst_stall", stall, 1'b0);
    chk_eq("async_rst_cnt", stall_cnt, 16'h0);
    chk_eq("async_rst_out", id_rs_out, id_rs_data);
    model_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
